// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants and
// a counter-width helper used to size the receiver's tick and bit counters.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;

  // Stop-phase tick counts for 1, 1.5 and 2 stop bits
  localparam int unsigned SB_TICK_1   = 16;
  localparam int unsigned SB_TICK_1P5 = 24;
  localparam int unsigned SB_TICK_2   = 32;

  // Bits needed to hold values 0..max_val (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable reset
// value so idle-high lines come out of reset in their idle state.
module sync_2ff #(
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled deserialiser with optional parity check,
// framing-error report and a one-cycle completion pulse with held outputs.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = SB_TICK_1,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            parity_err,
  output logic            frame_err
);

  localparam int unsigned S_MAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
  localparam int unsigned S_W   = cnt_width(S_MAX - 1);
  localparam int unsigned N_W   = cnt_width(DBIT - 1);

  localparam logic [S_W-1:0] S_MID      = S_W'(MID_SAMPLE);
  localparam logic [S_W-1:0] S_BIT_END  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP_END = S_W'(SB_TICK - 1);
  localparam logic [S_W-1:0] S_ONE      = S_W'(1);
  localparam logic [N_W-1:0] N_LAST     = N_W'(DBIT - 1);
  localparam logic [N_W-1:0] N_ONE      = N_W'(1);
  localparam logic           PAR_EN     = (PARITY_EN != 0);
  localparam logic           PAR_ODD    = (PARITY_ODD != 0);

  logic rx_s;

  uart_state_e     state_d, state_q;
  logic [S_W-1:0]  s_d, s_q;
  logic [N_W-1:0]  n_d, n_q;
  logic [DBIT-1:0] b_d, b_q;
  logic            par_bad_d, par_bad_q;
  logic            done_d, done_q;
  logic [DBIT-1:0] dout_d, dout_q;
  logic            parity_err_d, parity_err_q;
  logic            frame_err_d, frame_err_q;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // Next-state, datapath and completion-update logic
  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    b_d          = b_q;
    par_bad_d    = par_bad_q;
    done_d       = 1'b0;
    dout_d       = dout_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    unique case (state_q)
      IDLE: begin
        // Start edge is watched every clk so back-to-back frames lose nothing
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + S_ONE;
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_END) begin
            b_d = {rx_s, b_q[DBIT-1:1]};
            s_d = '0;
            if (n_q == N_LAST) begin
              state_d = PAR_EN ? PARITY : STOP;
            end else begin
              n_d = n_q + N_ONE;
            end
          end else begin
            s_d = s_q + S_ONE;
          end
        end
      end

      PARITY: begin
        if (s_tick) begin
          if (s_q == S_BIT_END) begin
            par_bad_d = (^b_q) ^ rx_s ^ PAR_ODD;
            s_d       = '0;
            state_d   = STOP;
          end else begin
            s_d = s_q + S_ONE;
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP_END) begin
            state_d      = IDLE;
            done_d       = 1'b1;
            dout_d       = b_q;
            frame_err_d  = ~rx_s;
            parity_err_d = PAR_EN & par_bad_q;
          end else begin
            s_d = s_q + S_ONE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      s_q          <= '0;
      n_q          <= '0;
      b_q          <= '0;
      par_bad_q    <= 1'b0;
      done_q       <= 1'b0;
      dout_q       <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      n_q          <= n_d;
      b_q          <= b_d;
      par_bad_q    <= par_bad_d;
      done_q       <= done_d;
      dout_q       <= dout_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_done_tick = done_q;
  assign dout         = dout_q;
  assign parity_err   = parity_err_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 instance and an 8E1 instance driven with serial
// frames, results compared against a frame-level reference model.
module tb_uart_rx;

  localparam int DBIT        = 8;
  localparam int BIT_CLKS    = 64;
  localparam int STOP_LOW    = 48;
  localparam int FRAME_TICKS = 8 + 16 * DBIT + 16;
  localparam int BUDGET      = 20000;

  logic            clk    = 1'b0;
  logic            reset  = 1'b1;
  logic            rx     = 1'b1;
  logic            rx_p   = 1'b1;
  logic            s_tick = 1'b0;
  logic            rx_done_tick, parity_err, frame_err;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick_p, parity_err_p, frame_err_p;
  logic [DBIT-1:0] dout_p;

  int vectors     = 0;
  int miscompares = 0;

  // Observed and expected results packed as {dout, parity_err, frame_err}
  logic [9:0] obs_q[$];
  logic [9:0] obs_p_q[$];
  logic [9:0] last_exp = '0;

  uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .parity_err   (parity_err),
    .frame_err    (frame_err)
  );

  uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx_p),
    .s_tick       (s_tick),
    .rx_done_tick (rx_done_tick_p),
    .dout         (dout_p),
    .parity_err   (parity_err_p),
    .frame_err    (frame_err_p)
  );

  always #5 clk = ~clk;

  // 16x baud tick: one clk high every 4 clk
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rx_done_tick)   obs_q.push_back({dout, parity_err, frame_err});
    if (rx_done_tick_p) obs_p_q.push_back({dout_p, parity_err_p, frame_err_p});
  end

  // Reference: data as sent, even parity over data+parity bit, stop bit level
  function automatic logic [9:0] model(input logic [7:0] data, input logic par_en,
                                       input logic par_bit, input logic stop_low);
    logic pe;
    pe = par_en && ((($countones(data) + int'(par_bit)) % 2) != 0);
    return {data, pe, stop_low};
  endfunction

  task automatic drive_line(input int which, input logic v);
    if (which == 0) rx = v;
    else            rx_p = v;
  endtask

  task automatic put_bit(input int which, input logic v);
    drive_line(which, v);
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input int which, input logic [7:0] data, input logic par_en,
                            input logic par_bit, input logic stop_low);
    put_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) put_bit(which, data[i]);
    if (par_en) put_bit(which, par_bit);
    if (stop_low) begin
      drive_line(which, 1'b0);
      repeat (STOP_LOW) @(negedge clk);
      drive_line(which, 1'b1);
      repeat (BIT_CLKS - STOP_LOW) @(negedge clk);
    end else begin
      put_bit(which, 1'b1);
    end
  endtask

  task automatic wait_obs(input int which, input int n);
    for (int i = 0; i < BUDGET; i++) begin
      if (((which == 0) ? obs_q.size() : obs_p_q.size()) >= n) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({rx_done_tick, dout, parity_err, frame_err} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_main: got %b, expected 0", {rx_done_tick, dout, parity_err, frame_err});
    end
    vectors++;
    if ({rx_done_tick_p, dout_p, parity_err_p, frame_err_p} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_par: got %b, expected 0", {rx_done_tick_p, dout_p, parity_err_p, frame_err_p});
    end
    reset = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [9:0] exp;
    int ticks, guard;
    exp = model(8'hA5, 1'b0, 1'b0, 1'b0);
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0);
      begin
        wait (rx == 1'b0);
        repeat (3) @(posedge clk);
        ticks = 0;
        guard = 0;
        while (ticks < FRAME_TICKS && guard < BUDGET) begin
          @(posedge clk);
          guard++;
          if (s_tick) ticks++;
        end
        #1;
        vectors++;
        if (rx_done_tick !== 1'b1) begin
          miscompares++;
          $display("FAIL basic_pulse_time: rx_done_tick=%b after %0d ticks, expected 1", rx_done_tick, ticks);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (rx_done_tick !== 1'b0) begin
          miscompares++;
          $display("FAIL basic_pulse_width: rx_done_tick=%b one clk later, expected 0", rx_done_tick);
        end
      end
    join
    wait_obs(0, 1);
    vectors++;
    if (obs_q.size() !== 1) begin
      miscompares++;
      $display("FAIL basic_count: got %0d frames, expected 1", obs_q.size());
    end
    if (obs_q.size() > 0) begin
      vectors++;
      if (obs_q[0] !== exp) begin
        miscompares++;
        $display("FAIL basic_frame: got %h, expected %h", obs_q[0], exp);
      end
    end
    last_exp = exp;
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp[2];
    exp[0] = model(8'h3C, 1'b0, 1'b0, 1'b0);
    exp[1] = model(8'hC3, 1'b0, 1'b0, 1'b0);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b0);
    wait_obs(0, 2);
    repeat (2 * BIT_CLKS) @(negedge clk);
    vectors++;
    if (obs_q.size() !== 2) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d frames, expected 2", obs_q.size());
    end
    for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL b2b_frame%0d: got %h, expected %h", i, obs_q[i], exp[i]);
      end
    end
    last_exp = exp[1];
    obs_q.delete();
  endtask

  task automatic test_glitch();
    drive_line(0, 1'b0);
    repeat (5 * 4) @(negedge clk);
    drive_line(0, 1'b1);
    repeat (3 * BIT_CLKS) @(negedge clk);
    vectors++;
    if (obs_q.size() !== 0) begin
      miscompares++;
      $display("FAIL glitch_pulse: got %0d frames, expected 0", obs_q.size());
    end
    vectors++;
    if ({dout, parity_err, frame_err} !== last_exp) begin
      miscompares++;
      $display("FAIL glitch_hold: got %h, expected %h", {dout, parity_err, frame_err}, last_exp);
    end
    obs_q.delete();
  endtask

  task automatic test_frame_err();
    logic [9:0] exp[2];
    logic [7:0] d;
    d = 8'($urandom);
    exp[0] = model(8'h55, 1'b0, 1'b0, 1'b1);
    exp[1] = model(d, 1'b0, 1'b0, 1'b0);
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
    repeat (2 * BIT_CLKS) @(negedge clk);
    send_frame(0, d, 1'b0, 1'b0, 1'b0);
    wait_obs(0, 2);
    vectors++;
    if (obs_q.size() !== 2) begin
      miscompares++;
      $display("FAIL ferr_count: got %0d frames, expected 2", obs_q.size());
    end
    for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL ferr_frame%0d: got %h, expected %h", i, obs_q[i], exp[i]);
      end
    end
    last_exp = exp[1];
    obs_q.delete();
  endtask

  task automatic test_parity();
    logic [9:0] exp[$];
    logic [7:0] d;
    logic       pb;
    exp.push_back(model(8'h07, 1'b1, 1'b1, 1'b0));
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b0);
    exp.push_back(model(8'h07, 1'b1, 1'b0, 1'b0));
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      d  = 8'($urandom);
      pb = 1'($urandom);
      exp.push_back(model(d, 1'b1, pb, 1'b0));
      send_frame(1, d, 1'b1, pb, 1'b0);
    end
    wait_obs(1, exp.size());
    vectors++;
    if (obs_p_q.size() !== exp.size()) begin
      miscompares++;
      $display("FAIL par_count: got %0d frames, expected %0d", obs_p_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < obs_p_q.size(); i++) begin
      vectors++;
      if (obs_p_q[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL par_frame%0d: got %h, expected %h", i, obs_p_q[i], exp[i]);
      end
    end
    obs_p_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] exp;
    put_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) put_bit(0, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({rx_done_tick, dout, parity_err, frame_err} !== 11'd0) begin
      miscompares++;
      $display("FAIL midrst_main: got %b, expected 0", {rx_done_tick, dout, parity_err, frame_err});
    end
    vectors++;
    if ({rx_done_tick_p, dout_p, parity_err_p, frame_err_p} !== 11'd0) begin
      miscompares++;
      $display("FAIL midrst_par: got %b, expected 0", {rx_done_tick_p, dout_p, parity_err_p, frame_err_p});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (6 * BIT_CLKS) @(negedge clk);
    vectors++;
    if (obs_q.size() !== 0) begin
      miscompares++;
      $display("FAIL midrst_pulse: got %0d frames, expected 0", obs_q.size());
    end
    obs_q.delete();
    exp = model(8'h12, 1'b0, 1'b0, 1'b0);
    send_frame(0, 8'h12, 1'b0, 1'b0, 1'b0);
    wait_obs(0, 1);
    vectors++;
    if (obs_q.size() !== 1 || obs_q[0] !== exp) begin
      miscompares++;
      $display("FAIL midrst_next: got %0d frames first %h, expected 1 frame %h",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 10'h0, exp);
    end
    last_exp = exp;
    obs_q.delete();
  endtask

  task automatic test_random();
    logic [9:0] exp[$];
    logic [7:0] d;
    logic       sl;
    int         gap;
    for (int k = 0; k < 16; k++) begin
      d   = 8'($urandom);
      sl  = ($urandom_range(0, 4) == 0);
      gap = sl ? 2 : int'($urandom_range(0, 2));
      exp.push_back(model(d, 1'b0, 1'b0, sl));
      send_frame(0, d, 1'b0, 1'b0, sl);
      repeat (gap * BIT_CLKS) @(negedge clk);
    end
    wait_obs(0, exp.size());
    vectors++;
    if (obs_q.size() !== exp.size()) begin
      miscompares++;
      $display("FAIL rand_count: got %0d frames, expected %0d", obs_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL rand_frame%0d: got %h, expected %h", i, obs_q[i], exp[i]);
      end
    end
    obs_q.delete();
  endtask

  initial begin
    repeat (4) @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_parity();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
